// File: rtl/ln_row_scheduler_if.sv
// Bus bundle between ln_row_scheduler and its command source, buffers and layer_norm.
// Every *_vld/*_rdy pair transfers one item on a rising clock edge where both are high;
// once asserted, vld holds with stable data until that transfer takes place.
interface ln_row_scheduler_if #(
    parameter int data_width = 16,
    parameter int p_ln       = 8,
    parameter int addr_width = 12
);
    localparam int bus_w = data_width * p_ln;

    logic                  cmd_vld;
    logic                  cmd_rdy;
    logic [15:0]           cmd_rows;
    logic [15:0]           cmd_len;
    logic [addr_width-1:0] cmd_src;
    logic [addr_width-1:0] cmd_dst;

    logic                  busy;
    logic                  done;

    logic                  rd_en;
    logic [addr_width-1:0] rd_addr;
    logic [bus_w-1:0]      rd_dat;

    logic [15:0]           ln_length;
    logic                  ln_up_vld;
    logic [bus_w-1:0]      ln_up_dat;
    logic                  ln_up_rdy;
    logic                  ln_dn_vld;
    logic [bus_w-1:0]      ln_dn_dat;
    logic                  ln_dn_rdy;

    logic                  wr_en;
    logic [addr_width-1:0] wr_addr;
    logic [bus_w-1:0]      wr_dat;

    // The scheduler side.
    modport master (
        input  cmd_vld, cmd_rows, cmd_len, cmd_src, cmd_dst,
        output cmd_rdy, busy, done,
        output rd_en, rd_addr,
        input  rd_dat,
        output ln_length, ln_up_vld, ln_up_dat,
        input  ln_up_rdy, ln_dn_vld, ln_dn_dat,
        output ln_dn_rdy,
        output wr_en, wr_addr, wr_dat
    );

    // The environment side: command source, buffers and layer_norm.
    modport slave (
        output cmd_vld, cmd_rows, cmd_len, cmd_src, cmd_dst,
        input  cmd_rdy, busy, done,
        input  rd_en, rd_addr,
        output rd_dat,
        input  ln_length, ln_up_vld, ln_up_dat,
        output ln_up_rdy, ln_dn_vld, ln_dn_dat,
        input  ln_dn_rdy,
        input  wr_en, wr_addr, wr_dat
    );
endinterface

// File: rtl/ln_row_scheduler.sv
// Runs multi-row LayerNorm jobs through one layer_norm: reads each row from the source
// buffer, streams it through layer_norm and writes the results, one row at a time.
module ln_row_scheduler #(
    parameter int data_width = 16,
    parameter int p_ln       = 8,
    parameter int addr_width = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ln_row_scheduler_if.master   sched,
    output logic [1:0]           dbg_state
);
    localparam int bus_w      = data_width * p_ln;
    localparam int beat_shift = $clog2(p_ln);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_d;

    logic [15:0]           rows_q;
    logic [15:0]           beats_q;
    logic [15:0]           len_q;
    logic [15:0]           row_cnt_q;
    logic [15:0]           rd_cnt_q;
    logic [15:0]           up_cnt_q;
    logic [15:0]           out_cnt_q;
    logic [addr_width-1:0] rd_base_q;
    logic [addr_width-1:0] wr_base_q;
    logic                  inflight_q;

    logic [bus_w-1:0]      fifo_mem_q [2];
    logic                  fifo_rd_ptr_q;
    logic                  fifo_wr_ptr_q;
    logic [1:0]            fifo_cnt_q;

    logic                  accept;
    logic [15:0]           cmd_beats;
    logic                  push;
    logic                  pop;
    logic [2:0]            slots_used;
    logic                  rd_go;
    logic                  wr_go;
    logic                  row_written;
    logic                  row_last;
    logic                  next_row;
    logic [addr_width-1:0] beats_addr;

    assign accept     = sched.cmd_vld & sched.cmd_rdy;
    assign cmd_beats  = sched.cmd_len >> beat_shift;
    assign beats_addr = addr_width'(beats_q);

    assign push = inflight_q;
    assign pop  = sched.ln_up_vld & sched.ln_up_rdy;

    // A head popping this cycle frees its slot, so a stream with ln_up_rdy held high
    // keeps one read per cycle while never holding more than two beats.
    assign slots_used = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};

    assign rd_go = (state_q == S_ISSUE) && (rd_cnt_q < beats_q) && (slots_used < 3'd2);
    assign wr_go = sched.ln_dn_vld & sched.ln_dn_rdy;

    assign row_written = (out_cnt_q == beats_q);
    assign row_last    = ((row_cnt_q + 16'd1) == rows_q);
    assign next_row    = (state_q == S_DRAIN) && row_written && !row_last;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if ((sched.cmd_rows == 16'd0) || (cmd_beats == 16'd0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // Every beat handed over implies every read was issued and returned.
                if (up_cnt_q == beats_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (row_written) begin
                    state_d = row_last ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rows_q     <= '0;
            beats_q    <= '0;
            len_q      <= '0;
            row_cnt_q  <= '0;
            rd_cnt_q   <= '0;
            up_cnt_q   <= '0;
            out_cnt_q  <= '0;
            rd_base_q  <= '0;
            wr_base_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= rd_go;
            if (accept) begin
                rows_q    <= sched.cmd_rows;
                beats_q   <= cmd_beats;
                len_q     <= sched.cmd_len;
                rd_base_q <= sched.cmd_src;
                wr_base_q <= sched.cmd_dst;
                row_cnt_q <= '0;
                rd_cnt_q  <= '0;
                up_cnt_q  <= '0;
                out_cnt_q <= '0;
            end else begin
                if (rd_go) begin
                    rd_cnt_q <= rd_cnt_q + 16'd1;
                end
                if (pop) begin
                    up_cnt_q <= up_cnt_q + 16'd1;
                end
                if (wr_go) begin
                    out_cnt_q <= out_cnt_q + 16'd1;
                end
                // Row bases advance by one row of beats; the sum wraps with the address.
                if (next_row) begin
                    row_cnt_q <= row_cnt_q + 16'd1;
                    rd_cnt_q  <= '0;
                    up_cnt_q  <= '0;
                    out_cnt_q <= '0;
                    rd_base_q <= rd_base_q + beats_addr;
                    wr_base_q <= wr_base_q + beats_addr;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            fifo_rd_ptr_q <= 1'b0;
            fifo_wr_ptr_q <= 1'b0;
            fifo_cnt_q    <= '0;
        end else begin
            if (push) begin
                fifo_mem_q[fifo_wr_ptr_q] <= sched.rd_dat;
                fifo_wr_ptr_q             <= ~fifo_wr_ptr_q;
            end
            if (pop) begin
                fifo_rd_ptr_q <= ~fifo_rd_ptr_q;
            end
            fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign sched.cmd_rdy   = (state_q == S_IDLE);
    assign sched.busy      = (state_q != S_IDLE);
    assign sched.done      = (state_q == S_DONE);

    assign sched.rd_en     = rd_go;
    assign sched.rd_addr   = rd_base_q + addr_width'(rd_cnt_q);

    assign sched.ln_length = len_q;
    assign sched.ln_up_vld = (fifo_cnt_q != 2'd0);
    assign sched.ln_up_dat = fifo_mem_q[fifo_rd_ptr_q];
    assign sched.ln_dn_rdy = (state_q == S_ISSUE) || (state_q == S_DRAIN);

    assign sched.wr_en     = wr_go;
    assign sched.wr_addr   = wr_base_q + addr_width'(out_cnt_q);
    assign sched.wr_dat    = sched.ln_dn_dat;

    assign dbg_state       = state_q;
endmodule

// File: tb/tb_ln_row_scheduler.sv
// Randomized bench for ln_row_scheduler: buffer and layer_norm models around the DUT,
// with a scoreboard of expected destination writes built from the job description.
module tb_ln_row_scheduler;
    localparam int data_width = 16;
    localparam int p_ln       = 8;
    localparam int addr_width = 12;
    localparam int bus_w      = data_width * p_ln;
    localparam int mem_words  = 1 << addr_width;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    ln_row_scheduler_if #(.data_width(data_width), .p_ln(p_ln), .addr_width(addr_width)) sched_bus ();

    ln_row_scheduler #(.data_width(data_width), .p_ln(p_ln), .addr_width(addr_width)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sched     (sched_bus),
        .dbg_state (dbg_state)
    );

    logic [bus_w-1:0]            src_mem [mem_words];
    logic [addr_width+bus_w-1:0] exp_q[$];
    logic [bus_w-1:0]            ln_in_q[$];
    logic [bus_w-1:0]            ln_out_q[$];

    int checks = 0;
    int errors = 0;
    int job_src = 0;
    int job_beats = 0;
    int up_rdy_mode = 0;
    int rd_seen = 0;
    int up_seen = 0;
    int wr_seen = 0;
    int done_cnt = 0;
    int cyc = 0;
    int first_rd_cyc = 0;
    int last_rd_cyc = 0;
    logic                  s_rd_en = 1'b0;
    logic [addr_width-1:0] s_rd_addr = '0;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stand-in for the normalisation: any fixed, data-dependent mapping will do.
    function automatic logic [bus_w-1:0] ln_fn(input logic [bus_w-1:0] x);
        return {x[63:0], x[127:64]} ^ {8{16'h5a3c}};
    endfunction

    // Environment: drive inputs on the falling edge, then sample what the next rising edge sees.
    initial begin
        int ln_beats;
        logic [addr_width+bus_w-1:0] e;
        sched_bus.ln_up_rdy = 1'b0;
        sched_bus.ln_dn_vld = 1'b0;
        sched_bus.ln_dn_dat = '0;
        sched_bus.rd_dat    = '0;
        forever begin
            @(negedge clk);
            if (s_rd_en) sched_bus.rd_dat = src_mem[s_rd_addr];
            else         sched_bus.rd_dat = {$urandom(), $urandom(), $urandom(), $urandom()};
            sched_bus.ln_up_rdy = (up_rdy_mode != 0) ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (ln_out_q.size() > 0) begin
                if (!sched_bus.ln_dn_vld) sched_bus.ln_dn_vld = ($urandom_range(0, 3) != 0);
                sched_bus.ln_dn_dat = ln_out_q[0];
            end else begin
                sched_bus.ln_dn_vld = 1'b0;
            end
            #1;
            cyc++;
            s_rd_en   = sched_bus.rd_en;
            s_rd_addr = sched_bus.rd_addr;
            if (!rst_n) begin
                s_rd_en = 1'b0;
                ln_in_q.delete();
                ln_out_q.delete();
                exp_q.delete();
            end else begin
                if (sched_bus.ln_up_vld && sched_bus.ln_up_rdy) begin
                    check("up_dat", sched_bus.ln_up_dat, src_mem[(job_src + up_seen) % mem_words]);
                    ln_in_q.push_back(sched_bus.ln_up_dat);
                    up_seen++;
                    ln_beats = int'(sched_bus.ln_length) / p_ln;
                    if (ln_in_q.size() == ln_beats) begin
                        foreach (ln_in_q[i]) ln_out_q.push_back(ln_fn(ln_in_q[i]));
                        ln_in_q.delete();
                    end
                end
                if (sched_bus.rd_en) begin
                    if (rd_seen == 0) first_rd_cyc = cyc;
                    last_rd_cyc = cyc;
                    check("rd_addr", sched_bus.rd_addr, (job_src + rd_seen) % mem_words);
                    if (job_beats > 0 && rd_seen > 0 && (rd_seen % job_beats) == 0)
                        check("row_no_overlap", wr_seen >= rd_seen, 1);
                    rd_seen++;
                    check("fifo_bound", (rd_seen - up_seen) <= 2, 1);
                end
                if (sched_bus.wr_en) begin
                    if (exp_q.size() == 0) begin
                        check("wr_extra", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", sched_bus.wr_addr, e[addr_width+bus_w-1:bus_w]);
                        check("wr_dat", sched_bus.wr_dat, e[bus_w-1:0]);
                    end
                    if (ln_out_q.size() > 0) void'(ln_out_q.pop_front());
                    wr_seen++;
                end
                if (sched_bus.done) done_cnt++;
            end
        end
    end

    task automatic start_job(input int rows, input int len, input int src, input int dst,
                             input int rdy, input int hold);
        int beats;
        logic [addr_width-1:0] a;
        beats       = len / p_ln;
        job_src     = src;
        job_beats   = beats;
        up_rdy_mode = rdy;
        rd_seen     = 0;
        up_seen     = 0;
        wr_seen     = 0;
        done_cnt    = 0;
        exp_q.delete();
        for (int r = 0; r < rows; r++) begin
            for (int b = 0; b < beats; b++) begin
                a = addr_width'((dst + r * beats + b) % mem_words);
                exp_q.push_back({a, ln_fn(src_mem[(src + r * beats + b) % mem_words])});
            end
        end
        @(negedge clk);
        sched_bus.cmd_vld  = 1'b1;
        sched_bus.cmd_rows = 16'(rows);
        sched_bus.cmd_len  = 16'(len);
        sched_bus.cmd_src  = addr_width'(src);
        sched_bus.cmd_dst  = addr_width'(dst);
        #2;
        check("cmd_rdy_idle", sched_bus.cmd_rdy, 1);
        @(negedge clk);
        if (hold != 0) begin
            sched_bus.cmd_rows = 16'(rows + 3);
            sched_bus.cmd_len  = 16'(len + 64);
            sched_bus.cmd_src  = addr_width'(src + 77);
            sched_bus.cmd_dst  = addr_width'(dst + 99);
        end else begin
            sched_bus.cmd_vld  = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget, input int len, input int hold);
        int n = 0;
        int bad_len = 0;
        int bad_rdy = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            #2;
            n++;
            if (hold != 0) begin
                if (sched_bus.ln_length != 16'(len)) bad_len++;
                if (sched_bus.cmd_rdy && !sched_bus.done) bad_rdy++;
            end
        end
        check("done_in_time", n < budget, 1);
        if (hold != 0) begin
            check("ln_length_stable", bad_len, 0);
            check("cmd_rdy_low_busy", bad_rdy, 0);
            @(negedge clk);
            sched_bus.cmd_vld = 1'b0;
        end
    endtask

    task automatic finish_job(input int rows, input int len);
        repeat (3) @(negedge clk);
        #2;
        check("busy_after", sched_bus.busy, 0);
        check("done_once", done_cnt, 1);
        check("rd_total", rd_seen, rows * (len / p_ln));
        check("wr_total", wr_seen, rows * (len / p_ln));
        check("exp_left", exp_q.size(), 0);
    endtask

    task automatic run_job(input int rows, input int len, input int src, input int dst, input int rdy);
        start_job(rows, len, src, dst, rdy, 0);
        wait_done(5000, len, 0);
        finish_job(rows, len);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_rdy"}, sched_bus.cmd_rdy, 1);
        check({tag, "_busy"}, sched_bus.busy, 0);
        check({tag, "_done"}, sched_bus.done, 0);
        check({tag, "_rd_en"}, sched_bus.rd_en, 0);
        check({tag, "_up_vld"}, sched_bus.ln_up_vld, 0);
        check({tag, "_dn_rdy"}, sched_bus.ln_dn_rdy, 0);
        check({tag, "_wr_en"}, sched_bus.wr_en, 0);
        check({tag, "_ln_length"}, sched_bus.ln_length, 0);
    endtask

    initial begin
        int rows;
        int len;
        int n;
        for (int i = 0; i < mem_words; i++)
            src_mem[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        sched_bus.cmd_vld  = 1'b0;
        sched_bus.cmd_rows = '0;
        sched_bus.cmd_len  = '0;
        sched_bus.cmd_src  = '0;
        sched_bus.cmd_dst  = '0;
        repeat (3) @(negedge clk);
        #2;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Single long row with a free-running consumer: back-to-back reads.
        start_job(1, 256, 0, 'h100, 0, 0);
        wait_done(5000, 256, 0);
        check("t1_rd_consecutive", last_rd_cyc - first_rd_cyc, 31);
        finish_job(1, 256);

        run_job(4, 64, 'h40, 'h200, 0);

        for (int j = 0; j < 3; j++) begin
            rows = $urandom_range(1, 4);
            len  = p_ln * $urandom_range(1, 20);
            run_job(rows, len, $urandom_range(0, mem_words - 1), $urandom_range(0, mem_words - 1), 1);
        end
        run_job(2, 64, 'hff8, 'hffc, 1);

        // Degenerate jobs complete immediately without touching the buffers.
        start_job(0, 256, 'h10, 'h20, 0, 0);
        #2;
        check("t4_rows0_done", sched_bus.done, 1);
        finish_job(0, 256);
        start_job(3, 0, 'h10, 'h20, 0, 0);
        #2;
        check("t4_len0_done", sched_bus.done, 1);
        finish_job(3, 0);

        // Abort in the middle of the second row.
        start_job(4, 64, 'h300, 'h500, 1, 0);
        n = 0;
        while (rd_seen < 10 && n < 500) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("t5_mid_row", rd_seen >= 10, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #2;
        check_reset_outputs("t5");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        check("t5_no_done", done_cnt, 0);
        check("t5_idle", sched_bus.busy, 0);
        run_job(3, 48, 'h123, 'h456, 1);

        // A command held valid throughout a job must not be taken.
        start_job(2, 128, 'h700, 'h800, 1, 1);
        wait_done(5000, 128, 1);
        finish_job(2, 128);
        check("t6_ln_length_kept", sched_bus.ln_length, 128);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors %0d", errors);
        $fatal(1, "watchdog");
    end
endmodule
